// File: rtl/onewire_reset_multi_if.sv
// Signal bundle between the 1-Wire transaction controller / pads and the
// multi-channel reset/presence engine.
interface onewire_reset_multi_if #(
  parameter int unsigned NUM_CH = 4
);
  logic              start;
  logic              overdrive;
  logic [NUM_CH-1:0] ch_mask;
  logic [NUM_CH-1:0] dq_in;
  logic [NUM_CH-1:0] dq_out_en;
  logic              busy;
  logic              done;
  logic [NUM_CH-1:0] presence;
  logic [NUM_CH-1:0] short_det;

  modport master (
    output start, overdrive, ch_mask, dq_in,
    input  dq_out_en, busy, done, presence, short_det
  );

  modport slave (
    input  start, overdrive, ch_mask, dq_in,
    output dq_out_en, busy, done, presence, short_det
  );
endinterface

// File: rtl/onewire_reset_multi.sv
// Multi-channel 1-Wire reset/presence engine with internal microsecond timebase.
// Define ONEWIRE_RST_SHORT_DET_EN to enable the bus-short check at tCHK.
module onewire_reset_multi #(
  parameter int unsigned CLKS_PER_US = 50,
  parameter int unsigned NUM_CH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  onewire_reset_multi_if.slave  bus
);

  localparam int unsigned PW = (CLKS_PER_US > 2) ? $clog2(CLKS_PER_US) : 1;
  localparam int unsigned UW = 10;

  localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_US - 1);

  localparam logic [UW-1:0] T_RSTL_STD = UW'(500);
  localparam logic [UW-1:0] T_RSTL_OD  = UW'(70);
  localparam logic [UW-1:0] T_CHK_STD  = UW'(5);
  localparam logic [UW-1:0] T_CHK_OD   = UW'(1);
  localparam logic [UW-1:0] T_WIN_STD  = UW'(70);
  localparam logic [UW-1:0] T_WIN_OD   = UW'(9);
  localparam logic [UW-1:0] T_REL_STD  = UW'(480);
  localparam logic [UW-1:0] T_REL_OD   = UW'(48);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE_LOW,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     presc, presc_nxt;
  logic [UW-1:0]     us_cnt, us_nxt;
  logic              mode, mode_nxt;
  logic [NUM_CH-1:0] mask, mask_nxt;
  logic [NUM_CH-1:0] dq_meta, dq_sync;
  logic [NUM_CH-1:0] oe, oe_nxt;
  logic              busy_r, busy_nxt;
  logic              done_r, done_nxt;
  logic [NUM_CH-1:0] pres_r, pres_nxt;
  logic [NUM_CH-1:0] short_r, short_nxt;

  logic              tick;
  logic [UW-1:0]     us_elapsed;
  logic [UW-1:0]     t_rstl, t_chk, t_win, t_rel;
  logic [NUM_CH-1:0] low_now;
  logic [NUM_CH-1:0] short_now;

  // Two-flop synchroniser for the asynchronous bus levels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dq_meta <= '1;
      dq_sync <= '1;
    end else begin
      dq_meta <= bus.dq_in;
      dq_sync <= dq_meta;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      presc   <= '0;
      us_cnt  <= '0;
      mode    <= 1'b0;
      mask    <= '0;
      oe      <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pres_r  <= '0;
      short_r <= '0;
    end else begin
      state   <= state_nxt;
      presc   <= presc_nxt;
      us_cnt  <= us_nxt;
      mode    <= mode_nxt;
      mask    <= mask_nxt;
      oe      <= oe_nxt;
      busy_r  <= busy_nxt;
      done_r  <= done_nxt;
      pres_r  <= pres_nxt;
      short_r <= short_nxt;
    end
  end

  // Timing thresholds follow the mode latched at start.
  always_comb begin
    t_rstl = mode ? T_RSTL_OD : T_RSTL_STD;
    t_chk  = mode ? T_CHK_OD  : T_CHK_STD;
    t_win  = mode ? T_WIN_OD  : T_WIN_STD;
    t_rel  = mode ? T_REL_OD  : T_REL_STD;
  end

  assign tick       = (presc == PRESC_MAX);
  assign us_elapsed = us_cnt + UW'(1);
  assign low_now    = mask & ~dq_sync;

  // Next-state, timebase and result logic.
  always_comb begin
    state_nxt = state;
    presc_nxt = tick ? '0 : presc + PW'(1);
    us_nxt    = tick ? us_elapsed : us_cnt;
    mode_nxt  = mode;
    mask_nxt  = mask;
    oe_nxt    = '0;
    pres_nxt  = pres_r;
    short_nxt = short_r;
    short_now = short_r;

    case (state)
      S_IDLE: begin
        presc_nxt = '0;
        us_nxt    = '0;
        if (bus.start) begin
          mode_nxt  = bus.overdrive;
          mask_nxt  = bus.ch_mask;
          pres_nxt  = '0;
          short_nxt = '0;
          if (bus.ch_mask == '0) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_PULSE_LOW;
            oe_nxt    = bus.ch_mask;
          end
        end
      end

      S_PULSE_LOW: begin
        oe_nxt = mask;
        if (tick && (us_elapsed == t_rstl)) begin
          state_nxt = S_RELEASE;
          oe_nxt    = '0;
        end
      end

      S_RELEASE: begin
        if (tick) begin
`ifdef ONEWIRE_RST_SHORT_DET_EN
          if (us_elapsed == t_chk) begin
            short_now = short_r | low_now;
          end
          short_nxt = short_now;
`endif
          // Window is inclusive of both tCHK and tWIN-end ticks.
          if ((us_elapsed >= t_chk) && (us_elapsed <= t_win)) begin
            pres_nxt = pres_r | (low_now & ~short_now);
          end
          if (us_elapsed == t_rel) begin
            state_nxt = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Timebase restarts on every state entry so phase lengths are exact.
    if (state_nxt != state) begin
      presc_nxt = '0;
      us_nxt    = '0;
    end

    busy_nxt = (state_nxt != S_IDLE);
    done_nxt = (state_nxt == S_DONE);
  end

  assign bus.dq_out_en = oe;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.presence  = pres_r;
  assign bus.short_det = short_r;

endmodule

// File: tb/tb_onewire_reset_multi.sv
// Directed bench for onewire_reset_multi: timing, presence, short, misuse, reset.
module tb_onewire_reset_multi;

  localparam int unsigned CPU = 50;
  localparam int unsigned NCH = 4;

  logic clk = 1'b0;
  logic rst_n;

  onewire_reset_multi_if #(.NUM_CH(NCH)) bus ();

  onewire_reset_multi #(.CLKS_PER_US(CPU), .NUM_CH(NCH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Device model: open-drain bus, optional presence pulse and stuck-low fault.
  logic [NCH-1:0] dev_ch;
  logic [NCH-1:0] stuck;
  int             dev_lo;
  int             dev_hi;
  int             since_rel = 1000000;
  logic           dev_on;

  assign dev_on    = (since_rel >= dev_lo) && (since_rel < dev_hi);
  assign bus.dq_in = ~(bus.dq_out_en | stuck | (dev_on ? dev_ch : '0));

  always @(posedge clk) begin
    if (|bus.dq_out_en) since_rel <= 0;
    else if (since_rel < 1000000) since_rel <= since_rel + 1;
  end

  // Cumulative activity counters, one count per clock cycle.
  int oe_cnt [NCH];
  int busy_cnt = 0;
  int done_cnt = 0;
  initial for (int i = 0; i < NCH; i++) oe_cnt[i] = 0;

  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) oe_cnt[i] <= oe_cnt[i] + int'(bus.dq_out_en[i]);
    busy_cnt <= busy_cnt + int'(bus.busy);
    done_cnt <= done_cnt + int'(bus.done);
  end

  int oe_base [NCH];
  int busy_base;
  int done_base;
  int n_checks = 0;
  int n_errors = 0;
  int lat;
  logic first_busy;
  logic [NCH-1:0] first_oe;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic snap();
    for (int i = 0; i < NCH; i++) oe_base[i] = oe_cnt[i];
    busy_base = busy_cnt;
    done_base = done_cnt;
  endtask

  function automatic int oe_delta(input int ch);
    return oe_cnt[ch] - oe_base[ch];
  endfunction

  // Issue one start; lat = cycle index (T+lat) at which done is seen, -1 on timeout.
  task automatic run_slot(input logic od, input logic [NCH-1:0] m, input int restart_at);
    @(negedge clk);
    snap();
    bus.start     = 1'b1;
    bus.overdrive = od;
    bus.ch_mask   = m;
    @(negedge clk);
    bus.start  = 1'b0;
    first_busy = bus.busy;
    first_oe   = bus.dq_out_en;
    lat = -1;
    for (int k = 0; k < 60000; k++) begin
      if (bus.done) begin
        lat = k + 1;
        break;
      end
      bus.start = (k == restart_at);
      if (k == restart_at) begin
        bus.ch_mask   = '1;
        bus.overdrive = ~od;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.overdrive = 1'b0;
    bus.ch_mask   = '0;
    dev_ch        = '0;
    stuck         = '0;
    dev_lo        = 0;
    dev_hi        = 0;
    repeat (3) @(negedge clk);
    check("rst_oe",       32'(bus.dq_out_en), 32'd0);
    check("rst_busy",     32'(bus.busy),      32'd0);
    check("rst_done",     32'(bus.done),      32'd0);
    check("rst_presence", 32'(bus.presence),  32'd0);
    check("rst_short",    32'(bus.short_det), 32'd0);
    rst_n = 1'b1;

    // Standard mode, ch0 answers 30..150 us after release, ch2 silent.
    dev_ch = 4'b0001; dev_lo = 30 * CPU; dev_hi = 150 * CPU;
    run_slot(1'b0, 4'b0101, -1);
    check("std_busy_first", 32'(first_busy),        32'd1);
    check("std_oe_first",   32'(first_oe),          32'b0101);
    check("std_done_lat",   32'(lat),               32'd49001);
    check("std_low_ch0",    32'(oe_delta(0)),       32'd25000);
    check("std_low_ch2",    32'(oe_delta(2)),       32'd25000);
    check("std_low_off",    32'(oe_delta(1) + oe_delta(3)), 32'd0);
    check("std_busy_len",   32'(busy_cnt - busy_base), 32'd49001);
    check("std_done_len",   32'(done_cnt - done_base), 32'd1);
    check("std_busy_after", 32'(bus.busy),          32'd0);
    check("std_presence",   32'(bus.presence),      32'b0001);
    check("std_short",      32'(bus.short_det),     32'd0);
    repeat (20) @(negedge clk);
    check("std_hold",       32'(bus.presence),      32'b0001);

    // Overdrive, ch0 answers 2..8 us after release.
    dev_ch = 4'b0001; dev_lo = 2 * CPU; dev_hi = 8 * CPU;
    run_slot(1'b1, 4'b0001, -1);
    check("od_done_lat",  32'(lat),           32'd5901);
    check("od_low_ch0",   32'(oe_delta(0)),   32'd3500);
    check("od_presence",  32'(bus.presence),  32'b0001);

    // ch1 stuck low for the whole slot.
    dev_ch = '0; stuck = 4'b0010;
    run_slot(1'b1, 4'b0010, -1);
    check("short_done_lat", 32'(lat), 32'd5901);
`ifdef ONEWIRE_RST_SHORT_DET_EN
    check("short_short",    32'(bus.short_det), 32'b0010);
    check("short_presence", 32'(bus.presence),  32'd0);
`else
    check("short_short",    32'(bus.short_det), 32'd0);
    check("short_presence", 32'(bus.presence),  32'b0010);
`endif
    stuck = '0;

    // Empty mask completes immediately and never drives the bus.
    run_slot(1'b0, 4'b0000, -1);
    check("empty_done_lat", 32'(lat), 32'd1);
    check("empty_oe",       32'(oe_delta(0) + oe_delta(1) + oe_delta(2) + oe_delta(3)), 32'd0);
    check("empty_busy_len", 32'(busy_cnt - busy_base), 32'd1);
    check("empty_presence", 32'(bus.presence),  32'd0);
    check("empty_short",    32'(bus.short_det), 32'd0);

    // Start re-pulsed mid-slot with a different mode and mask is ignored.
    dev_ch = 4'b0001; dev_lo = 2 * CPU; dev_hi = 8 * CPU;
    run_slot(1'b1, 4'b0001, 500);
    check("busy_start_lat",  32'(lat),           32'd5901);
    check("busy_start_ch0",  32'(oe_delta(0)),   32'd3500);
    check("busy_start_off",  32'(oe_delta(1) + oe_delta(2) + oe_delta(3)), 32'd0);
    check("busy_start_done", 32'(done_cnt - done_base), 32'd1);
    check("busy_start_pres", 32'(bus.presence),  32'b0001);

    // Reset during the low phase releases the bus and suppresses done.
    @(negedge clk);
    bus.start = 1'b1; bus.overdrive = 1'b1; bus.ch_mask = 4'b0001;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (100) @(negedge clk);
    check("mid_oe_before", 32'(bus.dq_out_en), 32'b0001);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_oe_after",   32'(bus.dq_out_en), 32'd0);
    check("mid_busy_after", 32'(bus.busy),      32'd0);
    check("mid_presence",   32'(bus.presence),  32'd0);
    snap();
    repeat (6500) @(negedge clk);
    check("mid_no_done", 32'(done_cnt - done_base), 32'd0);
    check("mid_no_busy", 32'(busy_cnt - busy_base), 32'd0);

    // Fresh start after reset completes normally.
    run_slot(1'b1, 4'b0001, -1);
    check("restart_lat",      32'(lat),          32'd5901);
    check("restart_low",      32'(oe_delta(0)),  32'd3500);
    check("restart_presence", 32'(bus.presence), 32'b0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
